// File: rtl/rv32i_axi_lite_master_if.sv
// AXI4-Lite master-side bus: AW, W, B, AR and R channels.
// The master modport belongs to the bridge and the slave modport to the memory or interconnect.
interface rv32i_axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/rv32i_axi_lite_master.sv
// Bridges the core's level-sensitive mem_req interface to AXI4-Lite, with one transaction outstanding.
// Zero-wait latency is 3 cycles from acceptance to the mem_valid pulse, and each slave wait cycle adds one.
module rv32i_axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic                    mem_instr,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W/8-1:0]     mem_wstrb,
  output logic                    mem_ready,
  output logic                    mem_valid,
  output logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_err,
  rv32i_axi_lite_master_if.master m
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                instr_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_hs;
  logic                w_hs;

  // Bus outputs come straight from captured registers, so nothing on the AXI side depends on mem_req combinationally.
  assign m.araddr = addr_q & ALIGN_MASK;
  assign m.awaddr = addr_q & ALIGN_MASK;
  assign m.arprot = {instr_q, 2'b00};
  assign m.awprot = 3'b000;
  assign m.wdata  = wdata_q;
  assign m.wstrb  = wstrb_q;

  assign aw_hs = m.awvalid && m.awready;
  assign w_hs  = m.wvalid && m.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (mem_req) begin
          state_n = mem_we ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        m.arvalid = 1'b1;
        if (m.arready) begin
          state_n = RD_DATA;
        end
      end
      RD_DATA: begin
        m.rready = 1'b1;
        if (m.rvalid) begin
          state_n = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or in the same cycle.
        m.awvalid = !aw_done;
        m.wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_n = WR_RESP;
        end
      end
      WR_RESP: begin
        m.bready = 1'b1;
        if (m.bvalid) begin
          state_n = DONE;
        end
      end
      DONE: begin
        mem_valid = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (mem_req) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
          instr_q <= mem_instr;
        end
      end
      if (state == WR_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      // SLVERR (2'b10) and DECERR (2'b11) both flag an error.
      if (state == RD_DATA && m.rvalid) begin
        mem_rdata <= m.rdata;
        mem_err   <= (m.rresp >= 2'b10);
      end
      if (state == WR_RESP && m.bvalid) begin
        mem_err <= (m.bresp >= 2'b10);
      end
    end
  end
endmodule

// File: tb/tb_rv32i_axi_lite_master.sv
// Directed and randomized transactions against a cycle-scheduled AXI-Lite slave.
// Expected per-cycle control levels, latencies and result registers come from closed-form timing rules.
module tb_rv32i_axi_lite_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  rv32i_axi_lite_master_if bus ();

  rv32i_axi_lite_master dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .m         (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] ctl_obs();
    return {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, mem_valid, mem_ready};
  endfunction

  task automatic slave_quiet();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = $urandom;
    bus.rresp   = 2'($urandom);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'($urandom);
  endtask

  // Requester idle for n cycles: block idle, results held.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle ctl", 64'(ctl_obs()), 64'(7'b0000001));
      check("idle rdata held", 64'(mem_rdata), 64'(exp_rdata));
      check("idle err held", 64'(mem_err), 64'(exp_err));
      mem_req = 1'b0;
      slave_quiet();
    end
  endtask

  // One transaction. d_a: AR (read) or AW (write) wait; d_w: W wait; d_r: R or B wait after entering that phase.
  task automatic run_txn(input string name, input logic we, input logic instr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int d_a, input int d_w, input int d_r,
                         input logic [31:0] rdata, input logic [1:0] resp);
    int          mx;
    int          done_c;
    logic [6:0]  expc;
    logic [31:0] aligned;
    aligned = addr & 32'hFFFF_FFFC;
    mx      = (we && d_w > d_a) ? d_w : d_a;
    done_c  = 3 + mx + d_r;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      expc = '0;
      if (!we) begin
        expc[6] = (c >= 1) && (c <= 1 + d_a);
        expc[5] = (c >= 2 + d_a) && (c <= 2 + d_a + d_r);
      end else begin
        expc[4] = (c >= 1) && (c <= 1 + d_a);
        expc[3] = (c >= 1) && (c <= 1 + d_w);
        expc[2] = (c >= 2 + mx) && (c <= 2 + mx + d_r);
      end
      expc[1] = (c == done_c);
      expc[0] = (c == 0);
      check($sformatf("%s ctl c%0d", name, c), 64'(ctl_obs()), 64'(expc));
      if (expc[6]) begin
        check($sformatf("%s araddr c%0d", name, c), 64'(bus.araddr), 64'(aligned));
        check($sformatf("%s arprot c%0d", name, c), 64'(bus.arprot), 64'({instr, 2'b00}));
      end
      if (expc[4]) begin
        check($sformatf("%s awaddr c%0d", name, c), 64'(bus.awaddr), 64'(aligned));
        check($sformatf("%s awprot c%0d", name, c), 64'(bus.awprot), 64'(3'b000));
      end
      if (expc[3]) begin
        check($sformatf("%s wdata c%0d", name, c), 64'(bus.wdata), 64'(wdata));
        check($sformatf("%s wstrb c%0d", name, c), 64'(bus.wstrb), 64'(wstrb));
      end
      if (c == done_c) begin
        if (!we) exp_rdata = rdata;
        exp_err = resp[1];
        check($sformatf("%s rdata", name), 64'(mem_rdata), 64'(exp_rdata));
        check($sformatf("%s err", name), 64'(mem_err), 64'(exp_err));
      end
      // Requester: present at c0, then scramble everything but mem_req (must be ignored until idle).
      mem_req = 1'b1;
      if (c == 0) begin
        mem_we    = we;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
      end else begin
        mem_we    = 1'($urandom);
        mem_instr = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
      slave_quiet();
      if (!we) begin
        bus.arready = (c == 1 + d_a);
        bus.rvalid  = (c == 2 + d_a + d_r);
        if (bus.rvalid) begin
          bus.rdata = rdata;
          bus.rresp = resp;
        end
      end else begin
        bus.awready = (c == 1 + d_a);
        bus.wready  = (c == 1 + d_w);
        bus.bvalid  = (c == 2 + mx + d_r);
        if (bus.bvalid) bus.bresp = resp;
      end
    end
  endtask

  initial begin
    slave_quiet();
    #1 rst = 1'b1;
    #2;
    check("reset ctl", 64'(ctl_obs()), 64'(7'b0000001));
    check("reset rdata", 64'(mem_rdata), 64'(0));
    check("reset err", 64'(mem_err), 64'(0));
    check("reset araddr", 64'(bus.araddr), 64'(0));
    check("reset awaddr", 64'(bus.awaddr), 64'(0));
    check("reset wdata", 64'(bus.wdata), 64'(0));
    check("reset wstrb", 64'(bus.wstrb), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    run_txn("rd0", 1'b0, 1'b1, 32'h0000_1003, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    idle_cycles(1);
    run_txn("rd_stall", 1'b0, 1'b0, 32'h0000_2004, 32'h0, 4'h0, 2, 0, 3, 32'hCAFE_F00D, 2'b00);
    idle_cycles(1);
    run_txn("wr_w_first", 1'b1, 1'b0, 32'h0000_3002, 32'h1234_5678, 4'b0011, 2, 0, 0, 32'h0, 2'b00);
    idle_cycles(1);
    run_txn("rd_slverr", 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 0, 1, 32'hBAD0_0001, 2'b10);
    run_txn("wr_ok", 1'b1, 1'b0, 32'h0000_4008, 32'hA5A5_5A5A, 4'b1111, 0, 1, 0, 32'h0, 2'b00);
    run_txn("b2b_rd", 1'b0, 1'b1, 32'h0000_5001, 32'h0, 4'h0, 1, 0, 0, 32'h0BAD_CAFE, 2'b00);
    run_txn("b2b_wr", 1'b1, 1'b0, 32'h0000_5005, 32'h7777_8888, 4'b1100, 0, 0, 2, 32'h0, 2'b11);
    idle_cycles(1);

    // Reset while the read is waiting in the data phase.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0000_6000;
    slave_quiet();
    @(negedge clk);
    check("rst_rd arvalid", 64'(bus.arvalid), 64'(1));
    bus.arready = 1'b1;
    @(negedge clk);
    check("rst_rd rready", 64'(bus.rready), 64'(1));
    bus.arready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rd ctl", 64'(ctl_obs()), 64'(7'b0000001));
    check("rst_rd rdata", 64'(mem_rdata), 64'(0));
    check("rst_rd err", 64'(mem_err), 64'(0));
    exp_rdata = '0;
    exp_err   = 1'b0;
    mem_req   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_txn("after_rst", 1'b0, 1'b0, 32'h0000_6004, 32'h0, 4'h0, 0, 0, 0, 32'h1357_9BDF, 2'b00);

    for (int i = 0; i < 40; i++) begin
      run_txn($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom, 2'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
